// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters.
// Operands are held for SETTLE cycles, then the result and flags are registered and returned tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_cmd,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carryout,
    output logic       rsp_zero,
    output logic       rsp_overflow,
    output logic       busy
);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e     state, state_next;
    logic       last_grant;
    logic [3:0] cnt;
    logic [3:0] a_q, b_q;
    logic [2:0] cmd_q;
    logic       id_q;
    logic       accept, grant_id;

    logic [3:0] alu_result;
    logic       alu_carryout, alu_zero, alu_overflow;
    logic [3:0] b_eff;
    logic       c_in;
    logic [4:0] sum;
    logic       sum_ovf;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time is granted.
                if (req0_valid && req1_valid) begin
                    req0_ready = last_grant;
                    req1_ready = !last_grant;
                end else begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid;
                end
                accept   = req0_ready | req1_ready;
                grant_id = req1_ready;
                if (accept) state_next = EXEC;
            end
            EXEC:    if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= 1'b1;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cmd_q        <= '0;
            id_q         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant_id ? req1_a   : req0_a;
                        b_q        <= grant_id ? req1_b   : req0_b;
                        cmd_q      <= grant_id ? req1_cmd : req0_cmd;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= id_q;
                        rsp_result   <= alu_result;
                        rsp_carryout <= alu_carryout;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                    end
                end
                RESP:    if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // ALU_4bit: SUB and SLT share the adder as a + ~b + 1; logic ops and SLT report carryout=overflow=0.
    always_comb begin
        b_eff   = (cmd_q == CMD_SUB || cmd_q == CMD_SLT) ? ~b_q : b_q;
        c_in    = (cmd_q == CMD_SUB || cmd_q == CMD_SLT);
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {4'b0000, c_in};
        sum_ovf = (a_q[3] == b_eff[3]) && (sum[3] != a_q[3]);

        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (cmd_q)
            CMD_ADD, CMD_SUB: begin
                alu_result   = sum[3:0];
                alu_carryout = sum[4];
                alu_overflow = sum_ovf;
            end
            CMD_XOR:  alu_result = a_q ^ b_q;
            CMD_SLT:  alu_result = {3'b000, sum[3] ^ sum_ovf};
            CMD_AND:  alu_result = a_q & b_q;
            CMD_NAND: alu_result = ~(a_q & b_q);
            CMD_NOR:  alu_result = ~(a_q | b_q);
            CMD_OR:   alu_result = a_q | b_q;
            default:  alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (round-robin rule, fixed latency, integer ALU arithmetic).
module tb_alu_arbiter;

    localparam int unsigned SETTLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_cmd = '0, req1_cmd = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carryout, rsp_zero, rsp_overflow, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy)
    );

    int n_assert = 0;
    int n_fail = 0;
    int phase = 0;   // 0 idle, 1 executing, 2 response pending
    int left = 0;
    int cyc = 0;
    bit lg = 1'b1;
    logic       p_id;
    logic [3:0] p_a, p_b;
    logic [2:0] p_cmd;
    logic       e_id = 1'b0;
    logic [3:0] e_res = '0;
    logic       e_c = 1'b0, e_z = 1'b0, e_o = 1'b0;
    int acc_cyc[$];
    bit acc_id[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cmd,
                           output logic [3:0] r, output logic c, output logic z, output logic o);
        int ua, ub, sa, sb, sv, res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 1'b0;
        o = 1'b0;
        res = 0;
        sv = 0;
        case (cmd)
            3'd0: begin res = ua + ub; c = (res > 15); sv = sa + sb; o = (sv > 7 || sv < -8); end
            3'd1: begin res = ua - ub; c = (ua >= ub); sv = sa - sb; o = (sv > 7 || sv < -8); end
            3'd2: res = ua ^ ub;
            3'd3: res = (sa < sb) ? 1 : 0;
            3'd4: res = ua & ub;
            3'd5: res = 15 - (ua & ub);
            3'd6: res = 15 - (ua | ub);
            default: res = ua | ub;
        endcase
        r = 4'(res & 15);
        z = (r == 4'd0);
    endtask

    task automatic check_rsp_fields();
        chk("rsp_valid", rsp_valid, phase == 2);
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_carryout", rsp_carryout, e_c);
        chk("rsp_zero", rsp_zero, e_z);
        chk("rsp_overflow", rsp_overflow, e_o);
    endtask

    task automatic step_cycle(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] c0,
                              input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] c1,
                              input bit rr);
        bit g0, g1, hs;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cmd = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cmd = c1;
        rsp_ready = rr;
        #1;
        g0 = (phase == 0) && v0 && (!v1 || lg);
        g1 = (phase == 0) && v1 && (!v0 || !lg);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("busy", busy, phase != 0);
        hs = (phase == 2) && rr;
        @(posedge clk);
        #1;
        cyc++;
        if (g0 || g1) begin
            phase = 1;
            left = SETTLE;
            p_id = g1;
            p_a = g1 ? a1 : a0;
            p_b = g1 ? b1 : b0;
            p_cmd = g1 ? c1 : c0;
            lg = g1;
            acc_cyc.push_back(cyc);
            acc_id.push_back(g1);
        end else if (phase == 1) begin
            left--;
            if (left == 0) begin
                phase = 2;
                e_id = p_id;
                alu_ref(p_a, p_b, p_cmd, e_res, e_c, e_z, e_o);
            end
        end else if (hs) begin
            phase = 0;
        end
        check_rsp_fields();
    endtask

    task automatic idle_step(input bit rr);
        step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd0, 4'd0, 3'd0, rr);
    endtask

    task automatic rand_step(input bit v0, input bit v1, input bit rr);
        step_cycle(v0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   v1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        phase = 0;
        lg = 1'b1;
        e_id = 1'b0; e_res = '0; e_c = 1'b0; e_z = 1'b0; e_o = 1'b0;
        chk("reset_busy", busy, 1'b0);
        check_rsp_fields();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && phase != 0; i++) idle_step(1'b1);
        chk("drain_timeout", 8'(phase), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single ADD with signed overflow, response exactly SETTLE cycles after accept
        do_reset();
        step_cycle(1'b1, 4'b0111, 4'b0001, 3'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        repeat (SETTLE) idle_step(1'b0);
        chk("t1_valid", rsp_valid, 1'b1);
        chk("t1_id", rsp_id, 1'b0);
        chk("t1_result", rsp_result, 4'b1000);
        chk("t1_carry", rsp_carryout, 1'b0);
        chk("t1_ovf", rsp_overflow, 1'b1);
        idle_step(1'b1);
        chk("t1_valid_drop", rsp_valid, 1'b0);

        // 2: simultaneous requests from reset, port 0 first
        do_reset();
        step_cycle(1'b1, 4'b0000, 4'b0001, 3'd1, 1'b1, 4'b1111, 4'b1111, 3'd1, 1'b0);
        repeat (SETTLE) step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1111, 4'b1111, 3'd1, 1'b0);
        chk("t2a_id", rsp_id, 1'b0);
        chk("t2a_result", rsp_result, 4'b1111);
        chk("t2a_zero", rsp_zero, 1'b0);
        step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1111, 4'b1111, 3'd1, 1'b1);
        step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1111, 4'b1111, 3'd1, 1'b0);
        repeat (SETTLE) idle_step(1'b0);
        chk("t2b_id", rsp_id, 1'b1);
        chk("t2b_result", rsp_result, 4'b0000);
        chk("t2b_zero", rsp_zero, 1'b1);
        idle_step(1'b1);

        // 3: both held valid, alternating grants at full throughput
        do_reset();
        acc_cyc.delete();
        acc_id.delete();
        repeat (6 * (SETTLE + 2)) rand_step(1'b1, 1'b1, 1'b1);
        chk("t3_count", 8'(acc_id.size()), 8'd6);
        for (int i = 0; i < acc_id.size(); i++) begin
            chk("t3_order", 8'(acc_id[i]), 8'(i % 2));
            if (i > 0) chk("t3_spacing", 8'(acc_cyc[i] - acc_cyc[i-1]), 8'(SETTLE + 2));
        end
        drain();

        // 4: response back-pressure holds everything stable
        rand_step(1'b1, 1'b0, 1'b0);
        repeat (SETTLE) idle_step(1'b0);
        repeat (5) rand_step(1'b1, 1'b1, 1'b0);
        chk("t4_busy", busy, 1'b1);
        idle_step(1'b1);
        chk("t4_valid_drop", rsp_valid, 1'b0);

        // 5: reset during EXEC abandons the operation
        rand_step(1'b1, 1'b0, 1'b0);
        idle_step(1'b0);
        do_reset();
        chk("t5_valid", rsp_valid, 1'b0);
        step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b0011, 4'b0011, 3'd0, 1'b0);
        repeat (SETTLE) idle_step(1'b0);
        chk("t5_id", rsp_id, 1'b1);
        chk("t5_result", rsp_result, 4'b0110);
        idle_step(1'b1);

        // 6: lone req1 granted immediately even though it was last granted
        step_cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1010, 4'b0101, 3'd7, 1'b0);
        chk("t6_busy", busy, 1'b1);
        drain();

        // random traffic with random back-pressure
        do_reset();
        repeat (400) rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
